me_control: RTL and testbench
=============================

ME_CONTROL -- requirements
Module: me_control

Interface
REQ-001 SHALL expose clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose start  input  1  search request, sampled only in IDLE.
REQ-004 SHALL expose AddressR  output  8  reference-block pixel index (row*16+col).
REQ-005 SHALL expose AddressS1, AddressS2  output  10 each  search-window pixel indices (row*32+col).
REQ-006 SHALL expose S1S2mux  output  16  per-PE search-operand select (1=S1, 0=S2).
REQ-007 SHALL expose NewDist  output  16  per-PE one-hot accumulator-clear strobe.
REQ-008 SHALL expose PEready  output  16  per-PE one-hot "distortion valid" strobe feeding the comparator.
REQ-009 SHALL expose VectorX, VectorY  output  4 each  two's-complement motion vector (-8..7) aligned to PEready.
REQ-010 SHALL expose CompStart  output  1  comparator enable; low re-initialises best distortion.
REQ-011 SHALL expose busy  output  1  high in RUN.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE when count=4111, DONE->RUN on start=1.
REQ-013 SHALL hold a 13-bit count, cleared to 0 on entering RUN and incremented by 1 every RUN cycle; no wrap.
REQ-014 SHALL decode all outputs combinationally from state and count (no extra pipeline stage); first RUN cycle presents count=0.
REQ-015 SHALL derive row=count[11:8]+count[7:4] (5-bit) and col=count[3:0]; AddressS1=row*32+col, AddressS2=row*32+col+16, AddressR=count[7:0].
REQ-016 SHALL set S1S2mux[i]=1 when col>=i, else 0.
REQ-017 SHALL assert NewDist[i] in RUN when count[7:0]=i, count<4096.
REQ-018 SHALL assert PEready[i] in RUN when count>=256, count[7:4]=0, count[3:0]=i; at most one bit high.
REQ-019 SHALL drive VectorX=i-8 and VectorY=(count[12:8]-1)-8 truncated to 4 bits whenever PEready[i]=1; hold last values otherwise.
REQ-020 SHALL drive CompStart=0 in IDLE and on the first RUN cycle after any start, 1 from count=1 through RUN and DONE.
REQ-021 SHALL ignore start while in RUN; a start held high in DONE SHALL launch a new search each completion.
REQ-022 SHALL drive AddressR/S1/S2, S1S2mux, NewDist, PEready to 0 outside RUN.

Reset
REQ-023 SHALL on rst_n=0, immediately force state=IDLE, count=0, VectorX=VectorY=0, CompStart=0, busy=0, all strobes 0, regardless of operation in progress.
REQ-024 SHALL resume from IDLE on the first rising edge after rst_n deasserts, requiring a fresh start.

Configuration
REQ-025 SHALL, with ME_CTRL_ABORT_EN defined, add input abort (1 bit); abort=1 in RUN forces IDLE next edge with CompStart=0 and strobes 0; abort has priority over start.
REQ-026 SHALL, without ME_CTRL_ABORT_EN, omit the abort port and its logic entirely.

Structure
REQ-027 SHALL place NUM_PE=16, BLK_DIM=16, WIN_DIM=32, COUNT_LAST=4111, address widths and the state enum in shared package me_pkg.
REQ-028 SHALL isolate the count->AddressR/S1/S2/S1S2mux decode in sub-module me_addr_gen (combinational).

Verification
REQ-029 SHALL cover reset then start pulse: busy=1 next cycle, count=0 -> AddressS1=0, AddressS2=16, NewDist=16'h0001, CompStart=0; CompStart=1 from second RUN cycle.
REQ-030 SHALL cover count=256: PEready=16'h0001, VectorX=4'h8 (-8), VectorY=4'h8 (-8); count=271: PEready=16'h8000, VectorX=4'h7.
REQ-031 SHALL cover count=0x1F3 (row=16, col=3): AddressS1=515, AddressS2=531, S1S2mux=16'h000F.
REQ-032 SHALL cover final drain: count=4111 gives PEready=16'h8000, VectorX=7, VectorY=7; next cycle DONE, busy=0, CompStart=1, strobes 0; total 4112 RUN cycles, 256 PEready pulses.
REQ-033 SHALL cover rst_n low at count=1000: all outputs at reset values asynchronously; start pulse in RUN mid-search ignored (count continues).
REQ-034 SHALL cover, with ME_CTRL_ABORT_EN, abort at count=300 with start=1 concurrently: IDLE next edge, CompStart=0, then restart on following start.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants, widths and state encoding for the
// motion-estimation search controller.
package me_pkg;

    localparam int NUM_PE  = 16;
    localparam int BLK_DIM = 16;
    localparam int WIN_DIM = 32;
    localparam int CNT_W   = 13;
    localparam int AR_W    = 8;
    localparam int AS_W    = 10;
    localparam int VEC_W   = 4;

    localparam logic [CNT_W-1:0] COUNT_LAST = 13'd4111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/me_control_if.sv
// Controller-to-datapath bundle: start/abort in, addresses,
// PE strobes, motion vector and comparator control out.
interface me_control_if;
    import me_pkg::*;

    logic              start;
`ifdef ME_CTRL_ABORT_EN
    logic              abort;
`endif
    logic [AR_W-1:0]   AddressR;
    logic [AS_W-1:0]   AddressS1;
    logic [AS_W-1:0]   AddressS2;
    logic [NUM_PE-1:0] S1S2mux;
    logic [NUM_PE-1:0] NewDist;
    logic [NUM_PE-1:0] PEready;
    logic [VEC_W-1:0]  VectorX;
    logic [VEC_W-1:0]  VectorY;
    logic              CompStart;
    logic              busy;

`ifdef ME_CTRL_ABORT_EN
    modport master (
        input  start, abort,
        output AddressR, AddressS1, AddressS2, S1S2mux,
        output NewDist, PEready, VectorX, VectorY,
        output CompStart, busy
    );
    modport slave (
        output start, abort,
        input  AddressR, AddressS1, AddressS2, S1S2mux,
        input  NewDist, PEready, VectorX, VectorY,
        input  CompStart, busy
    );
`else
    modport master (
        input  start,
        output AddressR, AddressS1, AddressS2, S1S2mux,
        output NewDist, PEready, VectorX, VectorY,
        output CompStart, busy
    );
    modport slave (
        output start,
        input  AddressR, AddressS1, AddressS2, S1S2mux,
        input  NewDist, PEready, VectorX, VectorY,
        input  CompStart, busy
    );
`endif

endinterface

// File: rtl/me_addr_gen.sv
// Combinational count -> reference/search address and
// per-PE S1/S2 operand select decode.
module me_addr_gen
    import me_pkg::*;
(
    input  logic              en_i,
    input  logic [11:0]       cnt_i,
    output logic [AR_W-1:0]   addr_r_o,
    output logic [AS_W-1:0]   addr_s1_o,
    output logic [AS_W-1:0]   addr_s2_o,
    output logic [NUM_PE-1:0] mux_o
);

    logic [4:0] row;
    logic [3:0] col;

    assign row = {1'b0, cnt_i[11:8]} + {1'b0, cnt_i[7:4]};
    assign col = cnt_i[3:0];

    // col < 16, so row*32+col and row*32+col+16 are pure concatenations
    always_comb begin
        addr_r_o  = '0;
        addr_s1_o = '0;
        addr_s2_o = '0;
        mux_o     = '0;
        if (en_i) begin
            addr_r_o  = cnt_i[7:0];
            addr_s1_o = {row, 1'b0, col};
            addr_s2_o = {row, 1'b1, col};
            for (int i = 0; i < NUM_PE; i++) begin
                mux_o[i] = (col >= i[3:0]);
            end
        end
    end

endmodule

// File: rtl/me_control.sv
// Full-search ME controller: IDLE/RUN/DONE sequencer over 4112 cycles.
// Optional ME_CTRL_ABORT_EN adds an abort input that returns RUN to IDLE.
module me_control
    import me_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    me_control_if.master bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   vx_q, vx_d;
    logic [VEC_W-1:0]   vy_q, vy_d;
    logic               run;
    logic               pe_hit;
    logic               nd_hit;
    logic [3:0]         pe_idx;
    logic [AR_W-1:0]    addr_r;
    logic [AS_W-1:0]    addr_s1;
    logic [AS_W-1:0]    addr_s2;
    logic [NUM_PE-1:0]  mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == COUNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef ME_CTRL_ABORT_EN
        if (state_q == RUN && bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
`endif
    end

    assign run    = (state_q == RUN);
    assign pe_idx = cnt_q[3:0];
    assign nd_hit = run && !cnt_q[12] && (cnt_q[7:4] == 4'd0);
    assign pe_hit = run && (cnt_q[12:8] != 5'd0)
                        && (cnt_q[7:4] == 4'd0);

    // i-8 flips the MSB; (row-1)-8 == row-9 modulo 16
    always_comb begin
        vx_d = vx_q;
        vy_d = vy_q;
        if (pe_hit) begin
            vx_d = {~pe_idx[3], pe_idx[2:0]};
            vy_d = 4'(cnt_q[11:8] - 4'd9);
        end
    end

    me_addr_gen u_addr (
        .en_i      (run),
        .cnt_i     (cnt_q[11:0]),
        .addr_r_o  (addr_r),
        .addr_s1_o (addr_s1),
        .addr_s2_o (addr_s2),
        .mux_o     (mux)
    );

    assign bus.AddressR  = addr_r;
    assign bus.AddressS1 = addr_s1;
    assign bus.AddressS2 = addr_s2;
    assign bus.S1S2mux   = mux;
    assign bus.NewDist   = nd_hit ? (NUM_PE'(1) << pe_idx) : '0;
    assign bus.PEready   = pe_hit ? (NUM_PE'(1) << pe_idx) : '0;
    assign bus.VectorX   = vx_d;
    assign bus.VectorY   = vy_d;
    assign bus.CompStart = (state_q == DONE)
                        || (run && cnt_q != '0);
    assign bus.busy      = run;

endmodule

// File: tb/tb_me_control.sv
// Directed testbench for me_control; define ME_CTRL_ABORT_EN
// to also exercise the abort path.
module tb_me_control;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    me_control_if bus();

    me_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
`ifdef ME_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.CompStart !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b comp=%b want 0 0",
                     bus.busy, bus.CompStart);
        end
        checks++;
        if (bus.PEready !== 16'h0 || bus.NewDist !== 16'h0
            || bus.S1S2mux !== 16'h0) begin
            errors++;
            $display("FAIL reset_strobes: pe=%h nd=%h mux=%h want 0",
                     bus.PEready, bus.NewDist, bus.S1S2mux);
        end
        checks++;
        if (bus.VectorX !== 4'h0 || bus.VectorY !== 4'h0
            || bus.AddressS1 !== 10'd0) begin
            errors++;
            $display("FAIL reset_vec: vx=%h vy=%h s1=%0d want 0 0 0",
                     bus.VectorX, bus.VectorY, bus.AddressS1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b want 0", bus.busy);
        end
    endtask

    // leaves the DUT in RUN at count=1
    task automatic test_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got %b want 1", bus.busy);
        end
        checks++;
        if (bus.AddressS1 !== 10'd0 || bus.AddressS2 !== 10'd16) begin
            errors++;
            $display("FAIL start_addr: s1=%0d s2=%0d want 0 16",
                     bus.AddressS1, bus.AddressS2);
        end
        checks++;
        if (bus.NewDist !== 16'h0001 || bus.CompStart !== 1'b0) begin
            errors++;
            $display("FAIL start_nd: nd=%h comp=%b want 0001 0",
                     bus.NewDist, bus.CompStart);
        end
        @(negedge clk);
        checks++;
        if (bus.CompStart !== 1'b1 || bus.NewDist !== 16'h0002) begin
            errors++;
            $display("FAIL second_cycle: comp=%b nd=%h want 1 0002",
                     bus.CompStart, bus.NewDist);
        end
    endtask

    // count 1 -> 272
    task automatic test_peready();
        repeat (255) @(negedge clk);
        checks++;
        if (bus.PEready !== 16'h0001 || bus.VectorX !== 4'h8
            || bus.VectorY !== 4'h8) begin
            errors++;
            $display("FAIL pe_256: pe=%h vx=%h vy=%h want 0001 8 8",
                     bus.PEready, bus.VectorX, bus.VectorY);
        end
        checks++;
        if (bus.NewDist !== 16'h0001) begin
            errors++;
            $display("FAIL nd_256: got %h want 0001", bus.NewDist);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.PEready !== 16'h8000 || bus.VectorX !== 4'h7
            || bus.VectorY !== 4'h8) begin
            errors++;
            $display("FAIL pe_271: pe=%h vx=%h vy=%h want 8000 7 8",
                     bus.PEready, bus.VectorX, bus.VectorY);
        end
        @(negedge clk);
        checks++;
        if (bus.PEready !== 16'h0 || bus.VectorX !== 4'h7
            || bus.NewDist !== 16'h0) begin
            errors++;
            $display("FAIL hold_272: pe=%h vx=%h nd=%h want 0 7 0",
                     bus.PEready, bus.VectorX, bus.NewDist);
        end
    endtask

    // count 272 -> 499 (0x1F3)
    task automatic test_addr();
        repeat (499 - 272) @(negedge clk);
        checks++;
        if (bus.AddressS1 !== 10'd515 || bus.AddressS2 !== 10'd531) begin
            errors++;
            $display("FAIL addr_1f3: s1=%0d s2=%0d want 515 531",
                     bus.AddressS1, bus.AddressS2);
        end
        checks++;
        if (bus.S1S2mux !== 16'h000F || bus.AddressR !== 8'hF3) begin
            errors++;
            $display("FAIL mux_1f3: mux=%h ar=%h want 000f f3",
                     bus.S1S2mux, bus.AddressR);
        end
    endtask

    // count 499 -> 1000, then asynchronous reset mid-search
    task automatic test_async_reset();
        repeat (600 - 499) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.AddressR !== 8'h59) begin
            errors++;
            $display("FAIL ignore_start: busy=%b ar=%h want 1 59",
                     bus.busy, bus.AddressR);
        end
        repeat (1000 - 601) @(negedge clk);
        checks++;
        if (bus.VectorX !== 4'h7 || bus.VectorY !== 4'hA
            || bus.AddressR !== 8'hE8) begin
            errors++;
            $display("FAIL pre_reset_1000: vx=%h vy=%h ar=%h want 7 a e8",
                     bus.VectorX, bus.VectorY, bus.AddressR);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.CompStart !== 1'b0
            || bus.VectorX !== 4'h0 || bus.VectorY !== 4'h0) begin
            errors++;
            $display("FAIL async_rst_ctl: busy=%b comp=%b vx=%h vy=%h",
                     bus.busy, bus.CompStart, bus.VectorX, bus.VectorY);
        end
        checks++;
        if (bus.AddressR !== 8'h0 || bus.AddressS2 !== 10'd0
            || bus.S1S2mux !== 16'h0 || bus.NewDist !== 16'h0) begin
            errors++;
            $display("FAIL async_rst_out: ar=%h s2=%0d mux=%h nd=%h",
                     bus.AddressR, bus.AddressS2, bus.S1S2mux, bus.NewDist);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL needs_fresh_start: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_drain();
        int runs;
        int pulses;
        bit multi;
        runs   = 0;
        pulses = 0;
        multi  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 5000 && bus.busy === 1'b1; k++) begin
            if (bus.PEready !== 16'h0) pulses++;
            if ($countones(bus.PEready) > 1) multi = 1'b1;
            if (runs == 4111) begin
                checks++;
                if (bus.PEready !== 16'h8000 || bus.VectorX !== 4'h7
                    || bus.VectorY !== 4'h7) begin
                    errors++;
                    $display("FAIL last_4111: pe=%h vx=%h vy=%h want 8000 7 7",
                             bus.PEready, bus.VectorX, bus.VectorY);
                end
            end
            bus.start = (runs == 1500);
            runs++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (runs != 4112 || pulses != 256 || multi) begin
            errors++;
            $display("FAIL drain_count: runs=%0d pulses=%0d multi=%b want 4112 256 0",
                     runs, pulses, multi);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.CompStart !== 1'b1) begin
            errors++;
            $display("FAIL done_ctl: busy=%b comp=%b want 0 1",
                     bus.busy, bus.CompStart);
        end
        checks++;
        if (bus.PEready !== 16'h0 || bus.NewDist !== 16'h0
            || bus.AddressS1 !== 10'd0 || bus.VectorX !== 4'h7) begin
            errors++;
            $display("FAIL done_out: pe=%h nd=%h s1=%0d vx=%h want 0 0 0 7",
                     bus.PEready, bus.NewDist, bus.AddressS1, bus.VectorX);
        end
    endtask

    // leaves the DUT in RUN at count=1
    task automatic test_restart_from_done();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.CompStart !== 1'b0
            || bus.NewDist !== 16'h0001) begin
            errors++;
            $display("FAIL restart: busy=%b comp=%b nd=%h want 1 0 0001",
                     bus.busy, bus.CompStart, bus.NewDist);
        end
        @(negedge clk);
        checks++;
        if (bus.CompStart !== 1'b1) begin
            errors++;
            $display("FAIL restart_comp: got %b want 1", bus.CompStart);
        end
    endtask

`ifdef ME_CTRL_ABORT_EN
    task automatic test_abort();
        repeat (300 - 1) @(negedge clk);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.CompStart !== 1'b0
            || bus.PEready !== 16'h0) begin
            errors++;
            $display("FAIL abort: busy=%b comp=%b pe=%h want 0 0 0",
                     bus.busy, bus.CompStart, bus.PEready);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b want 0", bus.busy);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.AddressS2 !== 10'd16
            || bus.CompStart !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: busy=%b s2=%0d comp=%b want 1 16 0",
                     bus.busy, bus.AddressS2, bus.CompStart);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start();
        test_peready();
        test_addr();
        test_async_reset();
        test_drain();
        test_restart_from_done();
`ifdef ME_CTRL_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
